// File: rtl/dec_pkg.sv
// dec_pkg: shared constants and helpers for the decoder syndrome stage.
//   - work-mode encodings and per-mode codeword/info/parity lengths
//   - parity-check matrices, one per mode, packed row-major
//     ({row5, ..., row0}, row0 in the least significant bits)
//   - FSM state encoding for the serial syndrome front end
//   - hcol(): column vector {row5[c], ..., row0[c]} of a mode's H matrix
package dec_pkg;

    localparam logic [1:0] MOD_1   = 2'b00;
    localparam logic [1:0] MOD_2   = 2'b01;
    localparam logic [1:0] MOD_3   = 2'b10;
    localparam logic [1:0] MOD_ILL = 2'b11;

    localparam int LEN_1  = 8;
    localparam int LEN_2  = 16;
    localparam int LEN_3  = 32;
    localparam int INFO_1 = 4;
    localparam int INFO_2 = 11;
    localparam int INFO_3 = 26;
    localparam int PAR_1  = LEN_1 - INFO_1;
    localparam int PAR_2  = LEN_2 - INFO_2;
    localparam int PAR_3  = LEN_3 - INFO_3;

    // H matrices are stored with six rows each; modes with fewer parity
    // bits carry all-zero rows at the top.
    localparam int H_ROWS = 6;
    localparam int COL_W  = 5;

    localparam logic [H_ROWS*LEN_1-1:0] H_MOD_1 = {
        8'h00, 8'h00, 8'hFF, 8'hE4, 8'hD2, 8'hB1
    };
    localparam logic [H_ROWS*LEN_2-1:0] H_MOD_2 = {
        16'h0000, 16'hFFFF, 16'hFE08, 16'hF1C4, 16'hCDA2, 16'hAB61
    };
    localparam logic [H_ROWS*LEN_3-1:0] H_MOD_3 = {
        32'hFFFFFFFF, 32'hFFFE0010, 32'hFF01FC08,
        32'hF0F1E384, 32'hCCCD9B42, 32'hAAAB56C1
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_ISSUE = 2'd2
    } state_e;

    // Codeword length for a work mode; 0 for the illegal encoding.
    function automatic int mode_len(input logic [1:0] mode);
        case (mode)
            MOD_1:   return LEN_1;
            MOD_2:   return LEN_2;
            MOD_3:   return LEN_3;
            default: return 0;
        endcase
    endfunction

    // Column c of the mode's H matrix, bit r taken from row r.
    // Only the column bits a mode can address are used for indexing, so
    // out-of-range columns never select outside a matrix.
    function automatic logic [H_ROWS-1:0] hcol(input logic [1:0]       mode,
                                               input logic [COL_W-1:0] col);
        logic [H_ROWS-1:0] v;
        v = '0;
        for (int r = 0; r < H_ROWS; r++) begin
            case (mode)
                MOD_1:   v[r] = (int'(col) < LEN_1) ? H_MOD_1[r*LEN_1 + int'(col[2:0])] : 1'b0;
                MOD_2:   v[r] = (int'(col) < LEN_2) ? H_MOD_2[r*LEN_2 + int'(col[3:0])] : 1'b0;
                MOD_3:   v[r] = H_MOD_3[r*LEN_3 + int'(col)];
                default: v[r] = 1'b0;
            endcase
        end
        return v;
    endfunction

endpackage

// File: rtl/dec_syn_acc.sv
// dec_syn_acc: column counter and syndrome accumulator.
// Each step XORs the H column selected by the counter into the accumulator
// when the matching codeword bit is set, then advances the counter. The
// counter stops at last_i instead of wrapping.
//   clk, rst     clock, async active-low reset
//   clear_i      zero counter and accumulator (priority over step_i)
//   step_i       process the current column
//   data_i       captured (masked) codeword
//   mode_i       captured work mode, selects the H matrix
//   last_i       index of the final column (L-1)
//   acc_nxt_o    accumulator value including the current column
//   done_o       step_i on the final column
module dec_syn_acc
    import dec_pkg::*;
#(
    parameter int CW_WIDTH  = 32,
    parameter int PAR_WIDTH = 6,
    parameter int CNT_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear_i,
    input  logic                 step_i,
    input  logic [CW_WIDTH-1:0]  data_i,
    input  logic [1:0]           mode_i,
    input  logic [CNT_WIDTH-1:0] last_i,
    output logic [PAR_WIDTH-1:0] acc_nxt_o,
    output logic                 done_o
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [PAR_WIDTH-1:0] acc_q, acc_d;
    logic [COL_W-1:0]     col_idx;
    logic [H_ROWS-1:0]    col_vec;
    logic [PAR_WIDTH-1:0] col_term;

    always_comb begin
        col_idx   = COL_W'(cnt_q);
        col_vec   = hcol(mode_i, col_idx);
        col_term  = data_i[cnt_q] ? col_vec[PAR_WIDTH-1:0] : '0;
        acc_nxt_o = acc_q ^ col_term;
        done_o    = step_i && (cnt_q == last_i);
    end

    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        if (clear_i) begin
            cnt_d = '0;
            acc_d = '0;
        end else if (step_i) begin
            acc_d = acc_nxt_o;
            cnt_d = done_o ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/dec_syndrome_serial.sv
// dec_syndrome_serial: accepts one codeword plus work mode, computes its
// parity-check syndrome one column per clock, then hands codeword, syndrome
// and mode to the check stage with a single-cycle chk_enable strobe.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | in_ready high, waiting for in_valid
//   ST_SHIFT | accumulating one H column per cycle, columns 0..L-1
//   ST_ISSUE | chk_enable (and mod_err if the mode was illegal) for 1 cycle
//
// Ports:
//   clk, rst                 clock, async active-low reset
//   in_valid / in_ready      codeword handshake
//   data_in                  received codeword, LSB = column 0
//   work_mod                 00=8b, 01=16b, 10=32b, 11=illegal
//   chk_enable               one-cycle strobe to the check stage
//   chk_data                 codeword with bits above L cleared
//   chk_s_vector             syndrome
//   chk_work_mod             captured mode
//   busy                     state is not IDLE
//   mod_err                  strobe alongside chk_enable for an illegal mode
module dec_syndrome_serial
    import dec_pkg::*;
#(
    parameter  int MAX_CODEWORD_WIDTH = 32,
    parameter  int MAX_INFO_WIDTH     = 26,
    localparam int MAX_PARITY_WIDTH   = MAX_CODEWORD_WIDTH - MAX_INFO_WIDTH,
    localparam int CNT_WIDTH          = $clog2(MAX_CODEWORD_WIDTH)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [MAX_CODEWORD_WIDTH-1:0] data_in,
    input  logic [1:0]                    work_mod,
    output logic                          chk_enable,
    output logic [MAX_CODEWORD_WIDTH-1:0] chk_data,
    output logic [MAX_PARITY_WIDTH-1:0]   chk_s_vector,
    output logic [1:0]                    chk_work_mod,
    output logic                          busy,
    output logic                          mod_err
);

    state_e state_q, state_d;

    logic [MAX_CODEWORD_WIDTH-1:0] data_q, data_d;
    logic [1:0]                    mod_q, mod_d;
    logic                          err_q, err_d;
    logic [MAX_CODEWORD_WIDTH-1:0] chk_data_q, chk_data_d;
    logic [MAX_PARITY_WIDTH-1:0]   chk_s_q, chk_s_d;
    logic [1:0]                    chk_mod_q, chk_mod_d;

    int                            in_len;
    int                            cap_len;
    logic                          in_illegal;
    logic [MAX_CODEWORD_WIDTH-1:0] in_mask;
    logic [MAX_CODEWORD_WIDTH-1:0] data_masked;
    logic                          accept;
    logic                          step;
    logic [CNT_WIDTH-1:0]          last_col;
    logic [MAX_PARITY_WIDTH-1:0]   acc_nxt;
    logic                          acc_done;

    // Input decode. An illegal mode has no defined length, so its word is
    // passed through unmasked; only mod_err and a zero syndrome matter then.
    always_comb begin
        in_len     = mode_len(work_mod);
        in_illegal = (work_mod == MOD_ILL) || (in_len > MAX_CODEWORD_WIDTH);
        for (int i = 0; i < MAX_CODEWORD_WIDTH; i++) begin
            in_mask[i] = in_illegal || (i < in_len);
        end
        data_masked = data_in & in_mask;
    end

    always_comb begin
        accept   = in_valid && (state_q == ST_IDLE);
        step     = (state_q == ST_SHIFT);
        cap_len  = mode_len(mod_q);
        last_col = CNT_WIDTH'(cap_len - 1);
    end

    dec_syn_acc #(
        .CW_WIDTH  (MAX_CODEWORD_WIDTH),
        .PAR_WIDTH (MAX_PARITY_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_acc (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (accept),
        .step_i    (step),
        .data_i    (data_q),
        .mode_i    (mod_q),
        .last_i    (last_col),
        .acc_nxt_o (acc_nxt),
        .done_o    (acc_done)
    );

    // FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = in_illegal ? ST_ISSUE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (acc_done) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready   = 1'b0;
        busy       = 1'b1;
        chk_enable = 1'b0;
        mod_err    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            ST_ISSUE: begin
                chk_enable = 1'b1;
                mod_err    = err_q;
            end
            default: ;
        endcase
    end

    // Capture and output registers. The chk_* registers load on the edge
    // that enters ISSUE, so they are stable for the strobe and hold until
    // the next word is issued. The syndrome uses the accumulator's next
    // value because the last column is folded in on that same edge.
    always_comb begin
        data_d     = data_q;
        mod_d      = mod_q;
        err_d      = err_q;
        chk_data_d = chk_data_q;
        chk_s_d    = chk_s_q;
        chk_mod_d  = chk_mod_q;
        if (accept) begin
            data_d = data_masked;
            mod_d  = work_mod;
            err_d  = in_illegal;
            if (in_illegal) begin
                chk_data_d = data_masked;
                chk_s_d    = '0;
                chk_mod_d  = work_mod;
            end
        end
        if (acc_done) begin
            chk_data_d = data_q;
            chk_s_d    = acc_nxt;
            chk_mod_d  = mod_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q     <= '0;
            mod_q      <= '0;
            err_q      <= 1'b0;
            chk_data_q <= '0;
            chk_s_q    <= '0;
            chk_mod_q  <= '0;
        end else begin
            data_q     <= data_d;
            mod_q      <= mod_d;
            err_q      <= err_d;
            chk_data_q <= chk_data_d;
            chk_s_q    <= chk_s_d;
            chk_mod_q  <= chk_mod_d;
        end
    end

    assign chk_data     = chk_data_q;
    assign chk_s_vector = chk_s_q;
    assign chk_work_mod = chk_mod_q;

endmodule

// File: tb/tb_dec_syndrome_serial.sv
module tb_dec_syndrome_serial;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] data_in = '0;
    logic [1:0]  work_mod = '0;
    logic        chk_enable;
    logic [31:0] chk_data;
    logic [5:0]  chk_s_vector;
    logic [1:0]  chk_work_mod;
    logic        busy;
    logic        mod_err;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dec_syndrome_serial dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .data_in      (data_in),
        .work_mod     (work_mod),
        .chk_enable   (chk_enable),
        .chk_data     (chk_data),
        .chk_s_vector (chk_s_vector),
        .chk_work_mod (chk_work_mod),
        .busy         (busy),
        .mod_err      (mod_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One word through the handshake; lat counts clock edges after the
    // handshake edge until chk_enable is seen (L for legal modes, 0 illegal).
    task automatic run_word(input string tag, input logic [31:0] d, input logic [1:0] m,
                            input logic [31:0] exp_data, input logic [5:0] exp_s,
                            input int exp_lat, input logic exp_err);
        int lat;
        @(negedge clk);
        chk({tag, "/ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        data_in  = d;
        work_mod = m;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        data_in  = '0;
        work_mod = 2'b00;
        chk({tag, "/busy"}, 32'(busy), 32'd1);
        lat = 0;
        while (!chk_enable && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "/lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "/s"}, 32'(chk_s_vector), 32'(exp_s));
        chk({tag, "/mod_err"}, 32'(mod_err), 32'(exp_err));
        chk({tag, "/mod"}, 32'(chk_work_mod), 32'(m));
        if (!exp_err) chk({tag, "/data"}, chk_data, exp_data);
        @(negedge clk);
        chk({tag, "/en_off"}, 32'(chk_enable), 32'd0);
        chk({tag, "/err_off"}, 32'(mod_err), 32'd0);
        chk({tag, "/idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [31:0] pw_data [4];
    logic [1:0]  pw_mod  [4];
    logic [5:0]  pw_s    [4];
    logic        pw_err  [4];
    int          pw_len  [4];

    initial begin
        int idx, n_iss, n_acc, t, last_t, ready_bad, en_seen;
        logic pend;

        // reset state
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst/in_ready", 32'(in_ready), 32'd1);
        chk("rst/busy", 32'(busy), 32'd0);
        chk("rst/chk_enable", 32'(chk_enable), 32'd0);
        chk("rst/mod_err", 32'(mod_err), 32'd0);
        chk("rst/chk_data", chk_data, 32'd0);
        chk("rst/chk_s", 32'(chk_s_vector), 32'd0);
        chk("rst/chk_mod", 32'(chk_work_mod), 32'd0);
        rst = 1'b1;

        // directed words: tag, data, mode, masked data, syndrome, latency, mod_err
        run_word("m0_zero",   32'h00000000, 2'b00, 32'h00000000, 6'h00, 8,  1'b0);
        run_word("m0_col0",   32'h00000001, 2'b00, 32'h00000001, 6'h09, 8,  1'b0);
        run_word("m1_col0",   32'h00000001, 2'b01, 32'h00000001, 6'h11, 16, 1'b0);
        run_word("m2_col0",   32'h00000001, 2'b10, 32'h00000001, 6'h21, 32, 1'b0);
        run_word("m1_mask",   32'hFFFF0003, 2'b01, 32'h00000003, 6'h03, 16, 1'b0);
        run_word("m0_col7",   32'h00000080, 2'b00, 32'h00000080, 6'h0F, 8,  1'b0);
        run_word("m0_ones",   32'hABCD00FF, 2'b00, 32'h000000FF, 6'h00, 8,  1'b0);
        run_word("m1_col15",  32'h00008000, 2'b01, 32'h00008000, 6'h1F, 16, 1'b0);
        run_word("m2_col31",  32'h80000000, 2'b10, 32'h80000000, 6'h3F, 32, 1'b0);
        run_word("m2_low16",  32'h0000FFFF, 2'b10, 32'h0000FFFF, 6'h1F, 32, 1'b0);
        run_word("m3_illegal",32'h12345678, 2'b11, 32'h00000000, 6'h00, 0,  1'b1);

        // back-to-back words with in_valid held high
        pw_data[0] = 32'h00000001; pw_mod[0] = 2'b00; pw_s[0] = 6'h09; pw_err[0] = 1'b0; pw_len[0] = 8;
        pw_data[1] = 32'h00000001; pw_mod[1] = 2'b01; pw_s[1] = 6'h11; pw_err[1] = 1'b0; pw_len[1] = 16;
        pw_data[2] = 32'h12345678; pw_mod[2] = 2'b11; pw_s[2] = 6'h00; pw_err[2] = 1'b1; pw_len[2] = 0;
        pw_data[3] = 32'h00000001; pw_mod[3] = 2'b10; pw_s[3] = 6'h21; pw_err[3] = 1'b0; pw_len[3] = 32;
        @(negedge clk);
        in_valid = 1'b1;
        data_in  = pw_data[0];
        work_mod = pw_mod[0];
        idx = 0; n_iss = 0; n_acc = 0; t = 0; last_t = 0; ready_bad = 0;
        pend = in_ready && in_valid;
        while (n_iss < 4 && t < 300) begin
            @(negedge clk);
            t++;
            if (pend) begin
                n_acc++;
                idx++;
                if (idx < 4) begin
                    data_in  = pw_data[idx];
                    work_mod = pw_mod[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (busy && in_ready) ready_bad++;
            if (chk_enable) begin
                chk("bp/ready_low", 32'(in_ready), 32'd0);
                chk("bp/s", 32'(chk_s_vector), 32'(pw_s[n_iss]));
                chk("bp/mod_err", 32'(mod_err), 32'(pw_err[n_iss]));
                if (n_iss > 0) chk("bp/gap", 32'(t - last_t), 32'(pw_len[n_iss] + 2));
                last_t = t;
                n_iss++;
            end
            pend = in_ready && in_valid;
        end
        chk("bp/issues", 32'(n_iss), 32'd4);
        chk("bp/accepts", 32'(n_acc), 32'd4);
        chk("bp/ready_busy", 32'(ready_bad), 32'd0);

        // reset pulse at cnt=5 of a mode-10 word
        @(negedge clk);
        in_valid = 1'b1;
        data_in  = 32'hFFFFFFFF;
        work_mod = 2'b10;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid/busy_before", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid/busy", 32'(busy), 32'd0);
        chk("mid/in_ready", 32'(in_ready), 32'd1);
        chk("mid/chk_enable", 32'(chk_enable), 32'd0);
        chk("mid/chk_s", 32'(chk_s_vector), 32'd0);
        chk("mid/chk_data", chk_data, 32'd0);
        chk("mid/chk_mod", 32'(chk_work_mod), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        en_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (chk_enable) en_seen++;
        end
        chk("mid/no_enable", 32'(en_seen), 32'd0);
        run_word("post_rst", 32'h80000001, 2'b10, 32'h80000001, 6'h1E, 32, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
